// File: rtl/mealy_seq_ctrl_if.sv
// rtl/mealy_seq_ctrl_if.sv - byte stream handshake into the Mealy detector sequencer
//
// Purpose: carries one parallel word per accepted transfer from a producer
//          to mealy_seq_ctrl.
// Ports (signals):
//   s_data  [DATA_W]  word, MSB shifted first         producer -> controller
//   s_valid           s_data valid                    producer -> controller
//   s_ready           controller accepts this cycle   controller -> producer
//   s_last            final word of a frame (only when SEQ_CTRL_FRAME_EN is defined)
// Modports: master = producer side, slave = controller side.
interface mealy_seq_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
`ifdef SEQ_CTRL_FRAME_EN
  logic              s_last;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
`else
  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
`endif
endinterface

// File: rtl/mealy_seq_ctrl.sv
// rtl/mealy_seq_ctrl.sv - word-to-bit sequencer, reset gate and hit counter for a serial Mealy detector
//
// Purpose: accepts parallel words, shifts them MSB-first into a bit-serial
//          Mealy detector, holds the detector in reset whenever no real data
//          is flowing, counts detector hits and raises a sticky threshold irq.
// Optional feature macro: SEQ_CTRL_FRAME_EN (adds s_last and a one-cycle
//          FLUSH state so that detection never spans frames).
// Ports:
//   clk        in            system clock, rising edge
//   reset      in            asynchronous active-low reset
//   s          slave modport word stream (s_data/s_valid/s_ready[/s_last])
//   det_bit    out           serial bit to the detector
//   det_rst    out           detector reset, high = held in reset
//   det_hit    in            detector output (combinational in det_bit)
//   thresh     in  [CNT_W]   irq threshold, 0 disables the irq
//   irq_clr    in            clears irq and hit_count
//   hit_count  out [CNT_W]   saturating hit count
//   irq        out           sticky threshold interrupt
//   underrun   out           one-cycle pulse when the stream breaks at a word end
//   busy       out           high while shifting
module mealy_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  mealy_seq_ctrl_if.slave  s,
  output logic             det_bit,
  output logic             det_rst,
  input  logic             det_hit,
  input  logic [CNT_W-1:0] thresh,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] hit_count,
  output logic             irq,
  output logic             underrun,
  output logic             busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

`ifdef SEQ_CTRL_FRAME_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              r_underrun;
  logic [CNT_W-1:0]  r_hit_count;
  logic              r_irq;
`ifdef SEQ_CTRL_FRAME_EN
  logic              r_last;
`endif

  logic              w_last_bit;
  logic              w_load;
  logic              w_shift;
  logic              w_underrun_nxt;
  logic              w_s_ready;
  logic              w_det_rst;
  logic              w_det_bit;
  logic              w_busy;
  logic              w_hit;
  logic              w_cnt_max;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_last_bit = (r_bit_idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs. s_ready, det_rst, det_bit and busy
  // depend only on registers; s_valid only steers the next state and load.
  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_shift        = 1'b0;
    w_underrun_nxt = 1'b0;
    w_s_ready      = 1'b0;
    w_det_rst      = 1'b1;
    w_det_bit      = 1'b0;
    w_busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_ready = 1'b1;
        if (s.s_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_det_rst = 1'b0;
        w_det_bit = r_shreg[DATA_W-1];
        w_busy    = 1'b1;
        if (!w_last_bit) begin
          w_shift = 1'b1;
        end else begin
`ifdef SEQ_CTRL_FRAME_EN
          // End of frame: refuse the next word so the detector gets flushed.
          if (r_last) begin
            w_state_nxt = ST_FLUSH;
          end else
`endif
          begin
            // Final bit: a waiting word continues the stream with no gap bit,
            // so the detector state carries across the word boundary.
            w_s_ready = 1'b1;
            if (s.s_valid) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt    = ST_IDLE;
              w_underrun_nxt = 1'b1;
            end
          end
        end
      end
`ifdef SEQ_CTRL_FRAME_EN
      ST_FLUSH: begin
        w_s_ready = 1'b1;
        if (s.s_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shift datapath and underrun pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg    <= '0;
      r_bit_idx  <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_underrun_nxt;
      if (w_load) begin
        r_shreg   <= s.s_data;
        r_bit_idx <= '0;
      end else if (w_shift) begin
        r_shreg   <= r_shreg << 1;
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end
    end
  end

`ifdef SEQ_CTRL_FRAME_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= 1'b0;
    end else if (w_load) begin
      r_last <= s.s_last;
    end
  end
`endif

  // Hit counter and sticky irq. A clear in the same cycle as a hit restarts
  // the count at 1, and with thresh==1 that restart sets irq again.
  assign w_hit     = (r_state == ST_SHIFT) && det_hit;
  assign w_cnt_max = (r_hit_count == {CNT_W{1'b1}});
  assign w_cnt_inc = r_hit_count + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit_count <= '0;
      r_irq       <= 1'b0;
    end else if (irq_clr) begin
      r_hit_count <= w_hit ? CNT_W'(1) : '0;
      r_irq       <= w_hit && (thresh == CNT_W'(1));
    end else if (w_hit && !w_cnt_max) begin
      r_hit_count <= w_cnt_inc;
      // Only the increment that lands on thresh sets irq; changing thresh
      // later never sets it retroactively.
      if ((thresh != '0) && (w_cnt_inc == thresh)) begin
        r_irq <= 1'b1;
      end
    end
  end

  assign s.s_ready = w_s_ready;
  assign det_rst   = w_det_rst;
  assign det_bit   = w_det_bit;
  assign busy      = w_busy;
  assign underrun  = r_underrun;
  assign hit_count = r_hit_count;
  assign irq       = r_irq;

endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// tb/tb_mealy_seq_ctrl.sv - randomized self-checking bench for mealy_seq_ctrl with an 11010 detector
module tb_mealy_seq_ctrl;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             det_bit, det_rst, det_hit;
  logic [CNT_W-1:0] thresh, hit_count;
  logic             irq_clr, irq, underrun, busy;

  always #5 clk = ~clk;

  mealy_seq_ctrl_if #(.DATA_W(DATA_W)) sif ();

  mealy_seq_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .s         (sif.slave),
    .det_bit   (det_bit),
    .det_rst   (det_rst),
    .det_hit   (det_hit),
    .thresh    (thresh),
    .irq_clr   (irq_clr),
    .hit_count (hit_count),
    .irq       (irq),
    .underrun  (underrun),
    .busy      (busy)
  );

  // 11010 Mealy detector, by bit history since its last reset.
  logic [3:0] d_hist;
  int         d_len;
  always @(posedge clk) begin
    if (det_rst) begin
      d_hist <= 4'd0;
      d_len  <= 0;
    end else begin
      d_hist <= {d_hist[2:0], det_bit};
      if (d_len < 4) d_len <= d_len + 1;
    end
  end
  assign det_hit = (d_len >= 4) && ({d_hist, det_bit} == 5'b11010);

  int n_total = 0;
  int n_bad   = 0;
  int ur_cnt  = 0;
  int irq_rise_at = -1;
  logic irq_q = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (underrun) ur_cnt++;
      if (irq && !irq_q) irq_rise_at = int'(hit_count);
    end
    irq_q = irq;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  logic [DATA_W-1:0] wq[$];
  int                gq[$];
`ifdef SEQ_CTRL_FRAME_EN
  logic              lq[$];
`endif

  task automatic push_word(input logic [DATA_W-1:0] w, input int g, input logic l);
    wq.push_back(w);
    gq.push_back(g);
`ifdef SEQ_CTRL_FRAME_EN
    lq.push_back(l);
`else
    if (l) check_eq("push_last_unsupported", 1, 0);
`endif
  endtask

  task automatic clear_q();
    wq.delete();
    gq.delete();
`ifdef SEQ_CTRL_FRAME_EN
    lq.delete();
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds s_valid until s_ready is seen at a clock edge; returns at edge+1.
  task automatic wait_accept();
    logic rdy;
    int   t;
    rdy = 1'b0;
    t   = 0;
    while (!rdy && t < 200) begin
      @(negedge clk);
      rdy = sif.s_ready;
      @(posedge clk);
      t++;
    end
    #1;
    check_eq("accept", int'(rdy), 1);
  endtask

  task automatic play();
    for (int i = 0; i < wq.size(); i++) begin
      sif.s_data  = wq[i];
      sif.s_valid = 1'b1;
`ifdef SEQ_CTRL_FRAME_EN
      sif.s_last  = lq[i];
`endif
      wait_accept();
      sif.s_valid = 1'b0;
      if (i < wq.size() - 1 && gq[i] > 0) begin
        repeat (DATA_W + gq[i] - 1) @(posedge clk);
        #1;
      end
    end
    tick(DATA_W + 3);
  endtask

  // Stream model: concatenate bits of each unbroken run and count 11010
  // occurrences; a gap, end of stream or end of frame restarts the search.
  function automatic int model_hits();
    int hits = 0;
    int run  = 0;
    logic [4:0] h = 5'd0;
    for (int i = 0; i < wq.size(); i++) begin
      for (int b = DATA_W - 1; b >= 0; b--) begin
        h = {h[3:0], wq[i][b]};
        run++;
        if (run >= 5 && h == 5'b11010) hits++;
      end
      if (i == wq.size() - 1 || gq[i] > 0) run = 0;
`ifdef SEQ_CTRL_FRAME_EN
      if (lq[i]) run = 0;
`endif
    end
    return hits;
  endfunction

  function automatic int model_underruns();
    int n = 0;
    for (int i = 0; i < wq.size(); i++) begin
      if (i == wq.size() - 1 || gq[i] > 0) begin
`ifdef SEQ_CTRL_FRAME_EN
        if (!lq[i]) n++;
`else
        n++;
`endif
      end
    end
    return n;
  endfunction

  task automatic restart(input int thr);
    thresh  = CNT_W'(thr);
    irq_clr = 1'b1;
    tick(1);
    irq_clr = 1'b0;
    ur_cnt  = 0;
    irq_rise_at = -1;
  endtask

  task automatic run_case(input string tag, input int thr);
    int hits, exp_cnt, exp_irq;
    restart(thr);
    play();
    hits    = model_hits();
    exp_cnt = (hits > CNT_MAX) ? CNT_MAX : hits;
    exp_irq = (thr != 0 && hits >= thr) ? 1 : 0;
    @(negedge clk);
    check_eq({tag, "_hit_count"}, int'(hit_count), exp_cnt);
    check_eq({tag, "_irq"}, int'(irq), exp_irq);
    check_eq({tag, "_irq_at"}, irq_rise_at, exp_irq ? thr : -1);
    check_eq({tag, "_underruns"}, ur_cnt, model_underruns());
    check_eq({tag, "_det_rst_idle"}, int'(det_rst), 1);
    tick(1);
  endtask

  logic [DATA_W-1:0] w1a;
  logic [DATA_W-1:0] pick[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    sif.s_data  = '0;
    sif.s_valid = 1'b0;
`ifdef SEQ_CTRL_FRAME_EN
    sif.s_last  = 1'b0;
`endif
    irq_clr = 1'b0;
    thresh  = '0;
    w1a     = 8'h1A;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_det_rst", int'(det_rst), 1);
    check_eq("rst_s_ready", int'(sif.s_ready), 1);
    check_eq("rst_hit_count", int'(hit_count), 0);
    check_eq("rst_irq", int'(irq), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_underrun", int'(underrun), 0);
    check_eq("rst_det_bit", int'(det_bit), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick(20);
    @(negedge clk);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_hit_count", int'(hit_count), 0);
    check_eq("idle_underruns", ur_cnt, 0);

    // Single word 0x1A: bit order, latency, hit and underrun
    restart(0);
    sif.s_data  = w1a;
    sif.s_valid = 1'b1;
    wait_accept();
    sif.s_valid = 1'b0;
    for (int k = 0; k < DATA_W; k++) begin
      @(negedge clk);
      check_eq($sformatf("w1a_bit%0d", k), int'(det_bit), int'(w1a[DATA_W-1-k]));
      check_eq($sformatf("w1a_rst%0d", k), int'(det_rst), 0);
    end
    tick(3);
    @(negedge clk);
    check_eq("w1a_hit_count", int'(hit_count), 1);
    check_eq("w1a_underruns", ur_cnt, 1);
    check_eq("w1a_det_rst_after", int'(det_rst), 1);
    check_eq("w1a_ready_after", int'(sif.s_ready), 1);

    // Cross-word pattern, back-to-back then with a one-cycle gap
    clear_q(); push_word(8'h06, 0, 1'b0); push_word(8'h80, 1, 1'b0);
    run_case("xword_b2b", 0);
    clear_q(); push_word(8'h06, 1, 1'b0); push_word(8'h80, 1, 1'b0);
    run_case("xword_gap", 0);

    // Threshold irq, then clear, then disabled threshold
    clear_q(); for (int i = 0; i < 3; i++) push_word(w1a, (i == 2) ? 1 : 0, 1'b0);
    run_case("thresh3", 3);
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    @(negedge clk);
    check_eq("clr_irq", int'(irq), 0);
    check_eq("clr_hit_count", int'(hit_count), 0);
    tick(1);
    run_case("thresh0", 0);

    // Saturation at 2^CNT_W-1
    clear_q(); for (int i = 0; i < CNT_MAX + 2; i++) push_word(w1a, (i == CNT_MAX + 1) ? 1 : 0, 1'b0);
    run_case("saturate", 0);

    // Clear in the same cycle as a hit, with thresh==1
    clear_q(); push_word(w1a, 1, 1'b0);
    run_case("thr1_first", 1);
    sif.s_data  = w1a;
    sif.s_valid = 1'b1;
    wait_accept();
    sif.s_valid = 1'b0;
    tick(DATA_W - 1);
    irq_clr = 1'b1;
    tick(1);
    irq_clr = 1'b0;
    @(negedge clk);
    check_eq("clr_on_hit_count", int'(hit_count), 1);
    check_eq("clr_on_hit_irq", int'(irq), 1);
    tick(DATA_W);
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    @(negedge clk);
    check_eq("clr_alone_irq", int'(irq), 0);
    check_eq("clr_alone_count", int'(hit_count), 0);

    // Asynchronous reset mid-word
    restart(0);
    ur_cnt = 0;
    sif.s_data  = w1a;
    sif.s_valid = 1'b1;
    wait_accept();
    sif.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_det_rst", int'(det_rst), 1);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_s_ready", int'(sif.s_ready), 1);
    #7 reset = 1'b1;
    tick(DATA_W + 4);
    check_eq("arst_underruns", ur_cnt, 0);
    check_eq("arst_hit_count", int'(hit_count), 0);

    // Frame boundary (with the macro: flushed, no hit; without: one hit)
`ifdef SEQ_CTRL_FRAME_EN
    clear_q(); push_word(8'h06, 0, 1'b1); push_word(8'h80, 1, 1'b0);
`else
    clear_q(); push_word(8'h06, 0, 1'b0); push_word(8'h80, 1, 1'b0);
`endif
    run_case("frame", 0);

    // Randomized streams against the stream model
    pick[0] = 8'h1A; pick[1] = 8'h06; pick[2] = 8'h80;
    pick[3] = 8'hD0; pick[4] = 8'h68; pick[5] = 8'h00;
    for (int t = 0; t < 12; t++) begin
      int nw;
      clear_q();
      nw = int'($urandom_range(1, 7));
      for (int i = 0; i < nw; i++) begin
        logic [DATA_W-1:0] w;
        int g;
        w = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom) : pick[$urandom_range(0, 5)];
        g = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
        if (i == nw - 1) g = 1;
        push_word(w, g, 1'b0);
      end
      run_case($sformatf("rnd%0d", t), int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
